// File: rtl/bp_be_fetch_buffer.sv
// FE packet buffer with separate read and commit pointers so speculative reads can be replayed.
// Define BP_BE_FETCH_BUFFER_BYPASS_EN to present an accepted packet on deq_o in the same cycle when empty.
module bp_be_fetch_buffer #(
    parameter int els_p   = 8,
    parameter int width_p = 128
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         fe_queue_i,
    input  logic                       fe_queue_v_i,
    output logic                       fe_queue_ready_o,
    output logic [width_p-1:0]         deq_o,
    output logic                       deq_v_o,
    input  logic                       deq_yumi_i,
    input  logic                       cmt_v_i,
    input  logic                       roll_v_i,
    input  logic                       clr_v_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);
    localparam int lg_els_lp = $clog2(els_p);
    localparam int ptr_w_lp  = lg_els_lp + 1;
    localparam int cnt_w_lp  = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] one_lp  = ptr_w_lp'(1);
    localparam logic [ptr_w_lp-1:0] full_lp = ptr_w_lp'(els_p);

    logic [ptr_w_lp-1:0] wptr_reg, rptr_reg, cptr_reg;
    logic [ptr_w_lp-1:0] wptr_next, rptr_next, cptr_next;
    logic [ptr_w_lp-1:0] occ;
    logic [width_p-1:0]  mem [els_p];
    logic                full, empty, enq, deq, cmt;

    // Occupancy is measured from the commit pointer: read slots stay reserved until retired.
    assign occ   = wptr_reg - cptr_reg;
    assign full  = (occ == full_lp);
    assign empty = (rptr_reg == wptr_reg);

    assign fe_queue_ready_o = ~full & ~clr_v_i & ~reset_i;
    assign enq     = fe_queue_v_i & fe_queue_ready_o;
    assign deq     = deq_yumi_i & deq_v_o;
    assign cmt     = cmt_v_i & (cptr_reg != rptr_reg);
    assign count_o = cnt_w_lp'(occ);

    always_comb begin
        deq_v_o = ~empty & ~roll_v_i & ~clr_v_i;
        deq_o   = mem[rptr_reg[lg_els_lp-1:0]];
`ifdef BP_BE_FETCH_BUFFER_BYPASS_EN
        if (empty & enq & ~roll_v_i) begin
            deq_v_o = 1'b1;
            deq_o   = fe_queue_i;
        end
`endif
    end

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        cptr_next = cptr_reg;
        if (clr_v_i) begin
            wptr_next = '0;
            rptr_next = '0;
            cptr_next = '0;
        end else begin
            if (enq) wptr_next = wptr_reg + one_lp;
            if (cmt) cptr_next = cptr_reg + one_lp;
            // Rollback lands on the commit pointer after this cycle's retirement.
            if (roll_v_i)
                rptr_next = cptr_next;
            else if (deq)
                rptr_next = rptr_reg + one_lp;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
            cptr_reg <= cptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr_reg[lg_els_lp-1:0]] <= fe_queue_i;
    end

    // Committing with nothing read-but-uncommitted is a consumer protocol error.
    assert property (@(posedge clk_i) disable iff (reset_i) !(cmt_v_i && (cptr_reg == rptr_reg)));

endmodule

// File: tb/tb_bp_be_fetch_buffer.sv
// Directed bench for bp_be_fetch_buffer (els_p=4, width_p=8): vector table plus reset, bypass and wrap sequences.
module tb_bp_be_fetch_buffer;
    localparam int ELS = 4;
    localparam int W   = 8;
`ifdef BP_BE_FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [W-1:0] fe_queue_i;
    logic         fe_queue_v_i;
    logic         fe_queue_ready_o;
    logic [W-1:0] deq_o;
    logic         deq_v_o;
    logic         deq_yumi_i;
    logic         cmt_v_i;
    logic         roll_v_i;
    logic         clr_v_i;
    logic [2:0]   count_o;

    int checks = 0;
    int failures = 0;

    bp_be_fetch_buffer #(.els_p(ELS), .width_p(W)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
        .deq_o(deq_o), .deq_v_o(deq_v_o), .deq_yumi_i(deq_yumi_i),
        .cmt_v_i(cmt_v_i), .roll_v_i(roll_v_i), .clr_v_i(clr_v_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         enq;
        logic [7:0] din;
        bit         yumi, cmt, roll, clr;
        bit         empty;  // rptr == wptr before this cycle
        bit         ev;
        logic [7:0] ed;
        int         ec;
        bit         er;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit enq, input logic [7:0] din, input bit yumi, input bit cmt,
                       input bit roll, input bit clr, input bit empty, input bit ev,
                       input logic [7:0] ed, input int ec, input bit er);
        vec_t v;
        v.enq = enq; v.din = din; v.yumi = yumi; v.cmt = cmt; v.roll = roll; v.clr = clr;
        v.empty = empty; v.ev = ev; v.ed = ed; v.ec = ec; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit enq, input logic [7:0] din, input bit yumi, input bit cmt,
                         input bit roll, input bit clr);
        fe_queue_v_i = enq; fe_queue_i = din; deq_yumi_i = yumi;
        cmt_v_i = cmt; roll_v_i = roll; clr_v_i = clr;
    endtask

    initial begin
        bit         byp;
        bit         ev;
        logic [7:0] ed;

        reset_i = 1'b1;
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_ready", {31'd0, fe_queue_ready_o}, 32'd0);
        check("reset_count", {29'd0, count_o}, 32'd0);
        check("reset_deq_v", {31'd0, deq_v_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("post_reset_ready", {31'd0, fe_queue_ready_o}, 32'd1);
        $display("reset: ready=%0d count=%0d deq_v=%0d", fe_queue_ready_o, count_o, deq_v_o);

        //  enq din    yu cm ro cl emp  ev ed     ec er
        add(1, 8'h0A, 0, 0, 0, 0, 1,   0, 8'h00, 0, 1);  // fill
        add(1, 8'h0B, 0, 0, 0, 0, 0,   1, 8'h0A, 1, 1);
        add(1, 8'h0C, 0, 0, 0, 0, 0,   1, 8'h0A, 2, 1);
        add(1, 8'h0D, 0, 0, 0, 0, 0,   1, 8'h0A, 3, 1);
        add(1, 8'h0E, 0, 0, 0, 0, 0,   1, 8'h0A, 4, 0);  // dropped while full
        add(0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h0A, 4, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0,   1, 8'h0A, 4, 0);  // ordered drain
        add(0, 8'h00, 1, 0, 0, 0, 0,   1, 8'h0B, 4, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0,   1, 8'h0C, 4, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0,   1, 8'h0D, 4, 0);
        add(1, 8'h0E, 0, 0, 0, 0, 1,   0, 8'h00, 4, 0);  // still full against cptr
        add(0, 8'h00, 0, 1, 0, 0, 1,   0, 8'h00, 4, 0);
        add(0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h00, 3, 1);
        add(0, 8'h00, 0, 1, 0, 0, 1,   0, 8'h00, 3, 1);
        add(0, 8'h00, 0, 1, 0, 0, 1,   0, 8'h00, 2, 1);
        add(0, 8'h00, 0, 1, 0, 0, 1,   0, 8'h00, 1, 1);
        add(1, 8'h0A, 0, 0, 0, 0, 1,   0, 8'h00, 0, 1);  // rollback
        add(1, 8'h0B, 0, 0, 0, 0, 0,   1, 8'h0A, 1, 1);
        add(1, 8'h0C, 0, 0, 0, 0, 0,   1, 8'h0A, 2, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0,   1, 8'h0A, 3, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0,   1, 8'h0B, 3, 1);
        add(0, 8'h00, 0, 1, 1, 0, 0,   0, 8'h00, 3, 1);
        add(1, 8'h0D, 0, 0, 0, 0, 0,   1, 8'h0B, 2, 1);  // replayed 0xB, then clear
        add(1, 8'h0F, 0, 0, 0, 1, 0,   0, 8'h00, 3, 0);
        add(0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h00, 0, 1);
        add(1, 8'h01, 0, 0, 0, 0, 1,   0, 8'h00, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0,   1, 8'h01, 1, 1);
        add(0, 8'h00, 0, 1, 0, 0, 1,   0, 8'h00, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h00, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_i);
            drive(tbl[i].enq, tbl[i].din, tbl[i].yumi, tbl[i].cmt, tbl[i].roll, tbl[i].clr);
            #1;
            byp = BYP && tbl[i].empty && tbl[i].enq && tbl[i].er && !tbl[i].roll && !tbl[i].clr;
            ev  = tbl[i].ev | byp;
            ed  = byp ? tbl[i].din : tbl[i].ed;
            check($sformatf("vec%0d_deq_v", i), {31'd0, deq_v_o}, {31'd0, ev});
            if (ev) check($sformatf("vec%0d_deq", i), {24'd0, deq_o}, {24'd0, ed});
            check($sformatf("vec%0d_count", i), {29'd0, count_o}, tbl[i].ec);
            check($sformatf("vec%0d_ready", i), {31'd0, fe_queue_ready_o}, {31'd0, tbl[i].er});
            $display("vec %0d: deq_v=%0d deq=%0h count=%0d ready=%0d", i, deq_v_o, deq_o, count_o, fe_queue_ready_o);
        end

        // Asynchronous reset with two entries held
        @(negedge clk_i); drive(1, 8'h21, 0, 0, 0, 0);
        @(negedge clk_i); drive(1, 8'h22, 0, 0, 0, 0);
        @(negedge clk_i); drive(0, 8'h00, 0, 0, 0, 0);
        #1;
        check("pre_async_count", {29'd0, count_o}, 32'd2);
        check("pre_async_deq_v", {31'd0, deq_v_o}, 32'd1);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_deq_v", {31'd0, deq_v_o}, 32'd0);
        check("async_count", {29'd0, count_o}, 32'd0);
        check("async_ready", {31'd0, fe_queue_ready_o}, 32'd0);
        $display("async reset: deq_v=%0d count=%0d ready=%0d", deq_v_o, count_o, fe_queue_ready_o);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("async_post_ready", {31'd0, fe_queue_ready_o}, 32'd1);

        // Enqueue into an empty buffer: same-cycle only with bypass
        @(negedge clk_i); drive(1, 8'h05, 0, 0, 0, 0);
        #1;
        check("empty_enq_deq_v", {31'd0, deq_v_o}, {31'd0, BYP});
        if (BYP) check("bypass_deq", {24'd0, deq_o}, 32'h05);
        $display("empty enq: deq_v=%0d deq=%0h", deq_v_o, deq_o);
        @(negedge clk_i); drive(0, 8'h00, 0, 0, 0, 0);
        #1;
        check("latency_deq_v", {31'd0, deq_v_o}, 32'd1);
        check("latency_deq", {24'd0, deq_o}, 32'h05);
        check("latency_count", {29'd0, count_o}, 32'd1);

        // Wrap-around: enqueue, dequeue and commit in the same cycle
        @(negedge clk_i); reset_i = 1'b1;
        @(negedge clk_i); reset_i = 1'b0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk_i);
            drive(k < 20, 8'(k), (k >= 1) && (k <= 20), k >= 2, 0, 0);
            #1;
            if (k >= 1 && k <= 20) begin
                check($sformatf("wrap%0d_deq_v", k), {31'd0, deq_v_o}, 32'd1);
                check($sformatf("wrap%0d_deq", k), {24'd0, deq_o}, 32'(k - 1));
            end
            if (k < 20) check($sformatf("wrap%0d_ready", k), {31'd0, fe_queue_ready_o}, 32'd1);
            $display("wrap %0d: deq_v=%0d deq=%0h count=%0d ready=%0d", k, deq_v_o, deq_o, count_o, fe_queue_ready_o);
        end
        @(negedge clk_i); drive(0, 8'h00, 0, 0, 0, 0);
        #1;
        check("wrap_end_count", {29'd0, count_o}, 32'd0);
        check("wrap_end_deq_v", {31'd0, deq_v_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bp_be_fetch_buffer.md
BP_BE_FETCH_BUFFER -- requirements
Module: bp_be_fetch_buffer

Interface
REQ-001 SHALL have parameter els_p, default 8, number of entries; power of two, minimum 2.
REQ-002 SHALL have parameter width_p, default 128, width of one FE queue packet in bits.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port fe_queue_i, input, width_p bits, packet arriving from the front end.
REQ-006 SHALL have port fe_queue_v_i, input, 1 bit, fe_queue_i valid.
REQ-007 SHALL have port fe_queue_ready_o, output, 1 bit, buffer accepts a packet this cycle.
REQ-008 SHALL have port deq_o, output, width_p bits, oldest unread packet.
REQ-009 SHALL have port deq_v_o, output, 1 bit, deq_o valid.
REQ-010 SHALL have port deq_yumi_i, input, 1 bit, consumer takes deq_o; legal only when deq_v_o is high.
REQ-011 SHALL have port cmt_v_i, input, 1 bit, retire the oldest read-but-uncommitted entry.
REQ-012 SHALL have port roll_v_i, input, 1 bit, return all read-but-uncommitted entries to unread.
REQ-013 SHALL have port clr_v_i, input, 1 bit, discard every entry.
REQ-014 SHALL have port count_o, output, $clog2(els_p+1) bits, number of entries held (wptr - cptr).

Function
REQ-015 SHALL keep write, read and commit pointers, each $clog2(els_p)+1 bits wide, with the MSB used as the wrap bit; all pointer arithmetic is modulo 2*els_p.
REQ-016 SHALL drive fe_queue_ready_o = (wptr - cptr != els_p) & ~clr_v_i & ~reset_i.
REQ-017 SHALL enqueue only on fe_queue_v_i & fe_queue_ready_o, writing fe_queue_i at wptr[low bits] and incrementing wptr; fe_queue_v_i while ready is low is ignored.
REQ-018 SHALL drive deq_v_o = (rptr != wptr) & ~roll_v_i & ~clr_v_i, and deq_o = mem[rptr low bits].
REQ-019 SHALL increment rptr on deq_yumi_i & deq_v_o.
REQ-020 SHALL increment cptr on cmt_v_i when cptr != rptr; cmt_v_i with cptr == rptr is ignored and flagged by an assertion.
REQ-021 SHALL, on roll_v_i, set rptr to the post-commit cptr: cptr+1 if a commit is valid in the same cycle, otherwise cptr. deq_yumi_i is ignored in that cycle, and an enqueue in that cycle still occurs.
REQ-022 SHALL, on clr_v_i, set all pointers to 0; clr_v_i takes priority over roll_v_i, cmt_v_i, deq_yumi_i and enqueue, and an enqueue presented in that cycle is dropped.
REQ-023 SHALL give one-cycle latency, without bypass, from an accepted enqueue to deq_v_o.
REQ-024 SHALL leave freed slots unavailable for writing until committed; full is defined against cptr, not rptr.
REQ-025 SHALL allow enqueue, dequeue and commit together in one cycle, each using the pre-edge pointers.

Reset
REQ-026 SHALL, while reset_i is high, immediately force wptr, rptr and cptr to 0, so that deq_v_o=0, count_o=0 and fe_queue_ready_o=0.
REQ-027 SHALL not reset the storage array contents.
REQ-028 SHALL assert fe_queue_ready_o in the first cycle after reset_i deasserts.

Configuration
REQ-029 SHALL honour macro BP_BE_FETCH_BUFFER_BYPASS_EN: when it is defined and rptr == wptr with no roll_v_i or clr_v_i, an accepted fe_queue_i SHALL appear on deq_o with deq_v_o=1 in the same cycle. A bypassed packet is still written, and deq_yumi_i advances rptr past it.
REQ-030 SHALL, when BP_BE_FETCH_BUFFER_BYPASS_EN is undefined, provide no combinational path from fe_queue_i or fe_queue_v_i to deq_o or deq_v_o; latency per REQ-023.

Verification
REQ-031 SHALL cover fill (els_p=4): enqueue 0xA,0xB,0xC,0xD with deq_yumi_i=0 -> count_o=4 and fe_queue_ready_o=0; a 5th packet 0xE is dropped.
REQ-032 SHALL cover ordered drain: from full, deq_yumi_i held high -> deq_o shows 0xA,0xB,0xC,0xD, then deq_v_o=0 and ready stays 0 until one cmt_v_i, after which ready=1.
REQ-033 SHALL cover rollback: enqueue 0xA,0xB,0xC; dequeue 0xA,0xB; cmt_v_i and roll_v_i in the same cycle -> next deq_o=0xB and count_o=2.
REQ-034 SHALL cover clear with simultaneous enqueue: 3 entries held, clr_v_i plus an enqueue of 0xF -> next cycle count_o=0 and deq_v_o=0, and 0xF is never output.
REQ-035 SHALL cover wrap-around: 20 cycles of enqueue, dequeue and commit each cycle with an incrementing pattern 0x00-0x13 -> output identical in order and no full assertion.
REQ-036 SHALL cover asynchronous reset: assert reset_i mid-cycle while holding 2 entries -> deq_v_o=0 before the next clock edge; with BYPASS_EN defined, enqueue 0x5 into an empty buffer -> deq_o=0x5 in the same cycle.
